// File: rtl/fetch_pkg.sv
// Shared definitions for the parametrised fetch/decode front end:
// instruction layout, opcode constants and per-opcode register usage.
package fetch_pkg;

  localparam int INSTR_BYTES = 2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_JMP  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LD   = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SYS  = 4'd7;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rt;
    logic [3:0] ra;
    logic [3:0] rb;
  } instr_t;

  function automatic logic writes_rt(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_ADDI, OP_LD, OP_SHL: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic reads_ra(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_ADDI, OP_LD, OP_SHL: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic reads_rb(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_decode_group_dep_check.sv
// Intra-group dependency check: for each valid lane and source operand,
// finds the youngest older lane in the same group that writes that register
// and reports its ROB tag; otherwise the lane's own tag is reported.
module group_dep_check
  import fetch_pkg::*;
#(
  parameter  int FETCH_W   = 4,
  parameter  int ROB_IDX_W = 4,
  localparam int CNT_W     = $clog2(FETCH_W + 1)
) (
  input  instr_t [FETCH_W-1:0]                lanes_i,
  input  logic   [CNT_W-1:0]                  count_i,
  input  logic   [ROB_IDX_W-1:0]              rob_alloc_idx_i,
  output logic   [FETCH_W-1:0]                a_dep_o,
  output logic   [FETCH_W-1:0]                b_dep_o,
  output logic   [FETCH_W-1:0][ROB_IDX_W-1:0] a_owner_o,
  output logic   [FETCH_W-1:0][ROB_IDX_W-1:0] b_owner_o
);

  // Scan older lanes in ascending order so the last match is the youngest producer.
  always_comb begin
    for (int j = 0; j < FETCH_W; j++) begin
      a_dep_o[j]   = 1'b0;
      b_dep_o[j]   = 1'b0;
      a_owner_o[j] = '0;
      b_owner_o[j] = '0;
      if (j < int'(count_i)) begin
        a_owner_o[j] = rob_alloc_idx_i + ROB_IDX_W'(j);
        b_owner_o[j] = rob_alloc_idx_i + ROB_IDX_W'(j);
        for (int k = 0; k < j; k++) begin
          if (writes_rt(lanes_i[k].opcode)) begin
            if (reads_ra(lanes_i[j].opcode) && (lanes_i[k].rt == lanes_i[j].ra)) begin
              a_dep_o[j]   = 1'b1;
              a_owner_o[j] = rob_alloc_idx_i + ROB_IDX_W'(k);
            end
            if (reads_rb(lanes_i[j].opcode) && (lanes_i[k].rt == lanes_i[j].rb)) begin
              b_dep_o[j]   = 1'b1;
              b_owner_o[j] = rob_alloc_idx_i + ROB_IDX_W'(k);
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/fetch_decode_group.sv
// Fetch/decode group front end: sequential PC generation with branch
// redirects, credit-limited capture of the returned icache group into a
// decode register, and a valid/ready group interface to the instruction
// buffer carrying decoded fields and intra-group producer tags.
// Optional build macro FETCH_PERF_CNT_EN adds capture/stall/redirect
// counters; without it the perf ports read zero.
module fetch_decode_group
  import fetch_pkg::*;
#(
  parameter  int              FETCH_W   = 4,
  parameter  int              PC_W      = 16,
  parameter  int              ROB_IDX_W = 4,
  parameter  logic [PC_W-1:0] RESET_PC  = '0,
  localparam int              CNT_W     = $clog2(FETCH_W + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               redirect_valid,
  input  logic [PC_W-1:0]                    redirect_pc,
  output logic                               icache_req,
  output logic [FETCH_W-1:0][PC_W-1:0]       icache_pc,
  input  logic                               icache_valid,
  input  logic [FETCH_W-1:0][15:0]           icache_instr,
  input  logic [CNT_W-1:0]                   ib_free,
  input  logic [ROB_IDX_W-1:0]               rob_alloc_idx,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CNT_W-1:0]                   out_count,
  output logic [PC_W-1:0]                    out_pc,
  output logic [FETCH_W-1:0][3:0]            out_opcode,
  output logic [FETCH_W-1:0][3:0]            out_rt,
  output logic [FETCH_W-1:0][3:0]            out_ra,
  output logic [FETCH_W-1:0][3:0]            out_rb,
  output logic [FETCH_W-1:0]                 out_a_dep,
  output logic [FETCH_W-1:0]                 out_b_dep,
  output logic [FETCH_W-1:0][ROB_IDX_W-1:0]  out_a_owner,
  output logic [FETCH_W-1:0][ROB_IDX_W-1:0]  out_b_owner,
  output logic [31:0]                        perf_groups,
  output logic [31:0]                        perf_stall_cycles,
  output logic [31:0]                        perf_redirects
);

  logic [PC_W-1:0]           pc_q, pc_d;
  logic                      d_valid_q, d_valid_d;
  logic [CNT_W-1:0]          d_count_q, d_count_d;
  logic [PC_W-1:0]           d_pc_q, d_pc_d;
  instr_t [FETCH_W-1:0]      d_lane_q, d_lane_d;
  logic [CNT_W-1:0]          n;
  logic                      capture;

  // Credit-limited lane count and the fetch request/capture qualifiers.
  always_comb begin
    n          = (ib_free > CNT_W'(FETCH_W)) ? CNT_W'(FETCH_W) : ib_free;
    icache_req = !rst && !redirect_valid && (!d_valid_q || out_ready);
    capture    = icache_req && icache_valid && (n != '0);
  end

  // Lane PCs are consecutive 2-byte instructions from pc_q, wrapping naturally.
  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      icache_pc[i] = pc_q + PC_W'(INSTR_BYTES * i);
    end
  end

  // Next state: redirect beats capture; otherwise a handshake empties D.
  always_comb begin
    pc_d      = pc_q;
    d_valid_d = d_valid_q;
    d_count_d = d_count_q;
    d_pc_d    = d_pc_q;
    d_lane_d  = d_lane_q;
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      d_valid_d = 1'b0;
    end else if (capture) begin
      pc_d      = pc_q + PC_W'(INSTR_BYTES * int'(n));
      d_valid_d = 1'b1;
      d_count_d = n;
      d_pc_d    = pc_q;
      for (int i = 0; i < FETCH_W; i++) begin
        if (i < int'(n)) begin
          d_lane_d[i] = instr_t'(icache_instr[i]);
        end else begin
          d_lane_d[i] = '0;
        end
      end
    end else if (d_valid_q && out_ready) begin
      d_valid_d = 1'b0;
    end
  end

  // PC and decode register; reset discards any held group without a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      d_valid_q <= 1'b0;
      d_count_q <= '0;
      d_pc_q    <= '0;
      d_lane_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      d_valid_q <= d_valid_d;
      d_count_q <= d_count_d;
      d_pc_q    <= d_pc_d;
      d_lane_q  <= d_lane_d;
    end
  end

  // Unused lanes are stored as zero, so fields read zero beyond out_count.
  always_comb begin
    out_valid = d_valid_q;
    out_count = d_count_q;
    out_pc    = d_pc_q;
    for (int i = 0; i < FETCH_W; i++) begin
      out_opcode[i] = d_lane_q[i].opcode;
      out_rt[i]     = d_lane_q[i].rt;
      out_ra[i]     = d_lane_q[i].ra;
      out_rb[i]     = d_lane_q[i].rb;
    end
  end

  group_dep_check #(
    .FETCH_W   (FETCH_W),
    .ROB_IDX_W (ROB_IDX_W)
  ) u_dep (
    .lanes_i         (d_lane_q),
    .count_i         (d_count_q),
    .rob_alloc_idx_i (rob_alloc_idx),
    .a_dep_o         (out_a_dep),
    .b_dep_o         (out_b_dep),
    .a_owner_o       (out_a_owner),
    .b_owner_o       (out_b_owner)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_groups_q;
  logic [31:0] perf_stall_q;
  logic [31:0] perf_redirects_q;
  logic        stall;

  // A stall is a cycle with no redirect where either nothing is requested or no credit exists.
  always_comb begin
    stall = !redirect_valid && (!icache_req || (n == '0));
  end

  // Free-running wrapping event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_groups_q    <= '0;
      perf_stall_q     <= '0;
      perf_redirects_q <= '0;
    end else begin
      if (capture)        perf_groups_q    <= perf_groups_q + 32'd1;
      if (stall)          perf_stall_q     <= perf_stall_q + 32'd1;
      if (redirect_valid) perf_redirects_q <= perf_redirects_q + 32'd1;
    end
  end

  assign perf_groups       = perf_groups_q;
  assign perf_stall_cycles = perf_stall_q;
  assign perf_redirects    = perf_redirects_q;
`else
  assign perf_groups       = '0;
  assign perf_stall_cycles = '0;
  assign perf_redirects    = '0;
`endif

endmodule

// File: tb/tb_fetch_decode_group.sv
// Scoreboard bench for fetch_decode_group: the driver issues directed and
// random cycles and pushes each predicted group; a monitor compares the
// presented group against the front of the queue every cycle.
module tb_fetch_decode_group;
  localparam int FW  = 4;
  localparam int PCW = 16;
  localparam int RW  = 4;
  localparam int CW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst, redirect_valid, icache_req, icache_valid;
  logic [PCW-1:0]            redirect_pc;
  logic [FW-1:0][PCW-1:0]    icache_pc;
  logic [FW-1:0][15:0]       icache_instr;
  logic [CW-1:0]             ib_free;
  logic [RW-1:0]             rob_alloc_idx;
  logic                      out_valid, out_ready;
  logic [CW-1:0]             out_count;
  logic [PCW-1:0]            out_pc;
  logic [FW-1:0][3:0]        out_opcode, out_rt, out_ra, out_rb;
  logic [FW-1:0]             out_a_dep, out_b_dep;
  logic [FW-1:0][RW-1:0]     out_a_owner, out_b_owner;
  logic [31:0]               perf_groups, perf_stall_cycles, perf_redirects;

  fetch_decode_group #(.FETCH_W(FW), .PC_W(PCW), .ROB_IDX_W(RW), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .icache_req(icache_req), .icache_pc(icache_pc), .icache_valid(icache_valid),
    .icache_instr(icache_instr), .ib_free(ib_free), .rob_alloc_idx(rob_alloc_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rt(out_rt), .out_ra(out_ra), .out_rb(out_rb),
    .out_a_dep(out_a_dep), .out_b_dep(out_b_dep),
    .out_a_owner(out_a_owner), .out_b_owner(out_b_owner),
    .perf_groups(perf_groups), .perf_stall_cycles(perf_stall_cycles),
    .perf_redirects(perf_redirects)
  );

  typedef struct packed {
    logic [PCW-1:0]      pc;
    logic [3:0]          cnt;
    logic [FW-1:0][15:0] ins;
  } grp_t;

  grp_t           q[$];
  logic [PCW-1:0] mpc;
  int             checks = 0;
  int             errors = 0;
  bit             mon_en = 1'b0;
  bit             hold_ins = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit op_writes(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
  endfunction
  function automatic bit op_reads_a(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
  endfunction
  function automatic bit op_reads_b(input logic [3:0] op);
    return op inside {4'd0, 4'd1};
  endfunction

  // Reference: search backwards from the lane for the nearest writer of each source.
  function automatic void model_deps(input grp_t g, input logic [RW-1:0] rob,
                                     output logic [FW-1:0] ad, output logic [FW-1:0] bd,
                                     output logic [FW-1:0][RW-1:0] ao,
                                     output logic [FW-1:0][RW-1:0] bo);
    ad = '0; bd = '0; ao = '0; bo = '0;
    for (int j = 0; j < int'(g.cnt); j++) begin
      ao[j] = rob + RW'(j);
      bo[j] = rob + RW'(j);
      if (op_reads_a(g.ins[j][15:12])) begin
        for (int k = j - 1; k >= 0; k--) begin
          if (op_writes(g.ins[k][15:12]) && g.ins[k][11:8] == g.ins[j][7:4]) begin
            ad[j] = 1'b1; ao[j] = rob + RW'(k); break;
          end
        end
      end
      if (op_reads_b(g.ins[j][15:12])) begin
        for (int k = j - 1; k >= 0; k--) begin
          if (op_writes(g.ins[k][15:12]) && g.ins[k][11:8] == g.ins[j][3:0]) begin
            bd[j] = 1'b1; bo[j] = rob + RW'(k); break;
          end
        end
      end
    end
  endfunction

  // One cycle: drive at negedge, check fetch side, update model at posedge, end at posedge+3.
  task automatic cyc(input bit r, input bit redir, input logic [PCW-1:0] rpc, input bit iv,
                     input int free, input bit rdy, input int rob);
    logic [FW-1:0][PCW-1:0] epc;
    int   n;
    grp_t g;
    @(negedge clk);
    rst = r; redirect_valid = redir; redirect_pc = rpc; icache_valid = iv;
    ib_free = CW'(free); out_ready = rdy;
    if (q.size() == 0) rob_alloc_idx = (rob >= 0) ? RW'(rob) : RW'($urandom_range(0, 15));
    if (!hold_ins) begin
      for (int i = 0; i < FW; i++)
        icache_instr[i] = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 3)),
                           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
    end
    #1;
    if (mon_en) begin
      chk("icache_req", icache_req, !r && !redir && (q.size() == 0 || rdy));
      for (int i = 0; i < FW; i++) epc[i] = mpc + PCW'(2 * i);
      chk("icache_pc", icache_pc, epc);
    end
    @(posedge clk);
    n = (free > FW) ? FW : free;
    if (r) begin
      mpc = 16'h0000; q.delete();
    end else if (redir) begin
      mpc = rpc; q.delete();
    end else if (iv && n > 0 && (q.size() == 0 || rdy)) begin
      g.pc = mpc; g.cnt = 4'(n);
      for (int i = 0; i < FW; i++) g.ins[i] = (i < n) ? icache_instr[i] : 16'h0000;
      q.push_back(g);
      mpc = mpc + PCW'(2 * n);
    end
    #3;
  endtask

  // Monitor: compare whatever group is presented against the scoreboard front.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (mon_en) begin
        chk("out_valid", out_valid, q.size() > 0);
        if (out_valid && q.size() > 0) begin
          grp_t g;
          logic [FW-1:0][3:0] eo, et, ea, eb;
          logic [FW-1:0] ad, bd;
          logic [FW-1:0][RW-1:0] ao, bo;
          g = q[0];
          for (int i = 0; i < FW; i++) begin
            eo[i] = (i < int'(g.cnt)) ? g.ins[i][15:12] : 4'd0;
            et[i] = (i < int'(g.cnt)) ? g.ins[i][11:8]  : 4'd0;
            ea[i] = (i < int'(g.cnt)) ? g.ins[i][7:4]   : 4'd0;
            eb[i] = (i < int'(g.cnt)) ? g.ins[i][3:0]   : 4'd0;
          end
          model_deps(g, rob_alloc_idx, ad, bd, ao, bo);
          chk("out_pc", out_pc, g.pc);
          chk("out_count", out_count, g.cnt);
          chk("out_fields", {out_opcode, out_rt, out_ra, out_rb}, {eo, et, ea, eb});
          chk("out_dep", {out_a_dep, out_b_dep}, {ad, bd});
          chk("out_owner", {out_a_owner, out_b_owner}, {ao, bo});
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [PCW-1:0] p0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; icache_valid = 1'b0;
    icache_instr = '0; ib_free = '0; rob_alloc_idx = '0; out_ready = 1'b0;
    mpc = '0;

    cyc(1, 0, 0, 0, 0, 0, -1);
    cyc(1, 0, 0, 0, 0, 0, -1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_dep_owner", {out_a_dep, out_b_dep, out_a_owner, out_b_owner}, 0);
    chk("rst_pc", icache_pc[0], 16'h0000);
    mon_en = 1'b1;

    // Sequential fetch with full credit.
    cyc(0, 0, 0, 1, 4, 1, -1);
    chk("seq_valid", out_valid, 1);
    chk("seq_count", out_count, 4);
    chk("seq_pc2", icache_pc, {16'd14, 16'd12, 16'd10, 16'd8});
    cyc(0, 0, 0, 1, 4, 1, -1);
    cyc(0, 0, 0, 0, 4, 1, -1);

    // Dependency chain with ROB tag wrap.
    hold_ins = 1'b1;
    icache_instr = {16'h7611, 16'h1541, 16'h0411, 16'h0123};
    cyc(0, 0, 0, 1, 4, 0, 14);
    chk("dep_l1", {out_a_dep[1], out_b_dep[1], out_a_owner[1], out_b_owner[1]}, {2'b11, 4'd14, 4'd14});
    chk("dep_l2", {out_a_dep[2], out_b_dep[2], out_a_owner[2], out_b_owner[2]}, {2'b11, 4'd15, 4'd14});
    chk("dep_l3", {out_a_dep[3], out_b_dep[3], out_a_owner[3]}, {2'b00, 4'd1});
    chk("dep_l0", out_a_dep[0], 0);
    hold_ins = 1'b0;

    // Partial credit, then backpressure.
    p0 = mpc;
    cyc(0, 0, 0, 1, 2, 1, -1);
    chk("part_count", out_count, 2);
    chk("part_pc", icache_pc[0], p0 + 16'd4);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 4, 0, -1);

    // Redirect while D is full and stalled.
    cyc(0, 1, 16'h0100, 1, 4, 0, -1);
    chk("redir_valid", out_valid, 0);
    chk("redir_pc", icache_pc[0], 16'h0100);

    // PC wrap.
    cyc(0, 1, 16'hFFFC, 0, 4, 1, -1);
    chk("wrap_pc", icache_pc, {16'h0002, 16'h0000, 16'hFFFE, 16'hFFFC});
    cyc(0, 0, 0, 1, 4, 1, -1);
    cyc(0, 0, 0, 1, 3, 1, -1);

    // Randomised traffic.
    for (int t = 0; t < 400; t++) begin
      cyc(($urandom % 64) == 0, ($urandom % 8) == 0, 16'($urandom), ($urandom % 4) != 0,
          $urandom_range(0, 7), $urandom % 2, -1);
    end

    // Reset mid-stall with D valid.
    cyc(0, 0, 0, 1, 4, 0, -1);
    cyc(0, 0, 0, 1, 4, 0, -1);
    chk("pre_rst_valid", out_valid, 1);
    cyc(1, 0, 0, 1, 4, 0, -1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_pc", icache_pc[0], 16'h0000);
    cyc(0, 0, 0, 1, 4, 1, -1);
    cyc(0, 0, 0, 0, 4, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
